ra_shadow_stack: RTL and testbench
==================================

RA_SHADOW_STACK -- requirements
Module: ra_shadow_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of shadow entries (power of two, >=2).
REQ-002 Parameter VLEN, default 32, virtual address width.
REQ-003 Parameter KEY, default 31'h73fa06c2, return-address XOR key shared with the branch unit.
REQ-004 The block SHALL have exactly one clock, and its reset SHALL be asynchronous and active-high, on the ports below.
REQ-005 Ports, one per line:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- en_i  in  1  checker enable.
- flush_i  in  1  empty the stack (context switch or debug entry).
- clear_i  in  1  leave TRIPPED.
- call_valid_i  in  1  committed call that writes ra.
- call_link_i  in  VLEN  encoded link value written to rd.
- ret_valid_i  in  1  committed return.
- ret_target_i  in  VLEN  decoded return target produced by the branch unit.
- check_valid_o  out  1  compare result valid.
- mismatch_o  out  1  return target differs from the shadow copy.
- crash_o  out  1  sticky violation flag.
- overflow_o  out  1  sticky: an entry was dropped.
- underflow_o  out  1  one-cycle pulse: return with the stack empty.
- depth_o  out  $clog2(DEPTH+1)  current entry count.

Function
REQ-006 Push value = call_link_i[30:0] ^ KEY (31-bit plain return PC); stored in a DEPTH x 31 circular buffer.
REQ-007 Return compare: ret_target_i[VLEN-1]==1 AND ret_target_i[30:0]==popped entry -> match; otherwise mismatch.
REQ-008 Results are registered: check_valid_o and mismatch_o assert exactly 1 cycle after ret_valid_i with a non-empty stack, for one cycle.
REQ-009 FSM states: DISABLED, ACTIVE, TRIPPED.
- DISABLED -> ACTIVE when en_i=1.
- ACTIVE -> DISABLED when en_i=0; the stack is emptied.
- ACTIVE -> TRIPPED on a mismatch.
- TRIPPED -> ACTIVE on clear_i; the stack is emptied.
REQ-010 In DISABLED, no pushes, no pops, and all pulse outputs are 0.
REQ-011 crash_o = 1 iff state is TRIPPED; it asserts in the same cycle as mismatch_o.
REQ-012 In TRIPPED, pushes and pops are ignored and depth_o is held.
REQ-013 Push when full: overwrite the oldest entry (wrap), depth stays DEPTH, set overflow_o (sticky until reset or flush_i).
REQ-014 Return when empty: no compare, check_valid_o=0, underflow_o pulses 1 cycle later, depth stays 0, no state change.
REQ-015 Call and return in the same cycle: pop and compare the top first, then write the new value into the freed slot; net depth is unchanged.
REQ-016 flush_i has priority over call and return in the same cycle: depth=0, overflow_o cleared, no check issued; the state is unchanged.
REQ-017 clear_i and a mismatch in the same cycle: clear_i wins, the state goes to ACTIVE, and the mismatch is still reported on mismatch_o.
REQ-018 The top pointer is log2(DEPTH) bits and wraps modulo DEPTH on both push and pop.

Reset
REQ-019 rst_i asserted at any time, including mid-compare: state=DISABLED, depth_o=0, top pointer=0, and all outputs 0 asynchronously.
REQ-020 Storage contents are not reset; an entry is valid only when it is below depth_o.
REQ-021 The first push or pop can occur in the first cycle after rst_i deasserts with en_i=1 (which enters ACTIVE), acting from the following cycle.

Verification
REQ-022 Match: en_i=1; call_link_i=0x73fa16c2 (plain 0x1000); ret_target_i=0x80001000 -> next cycle check_valid_o=1, mismatch_o=0, depth_o 1->0.
REQ-023 Mismatch: same push; ret_target_i=0x80001004 -> mismatch_o=1, crash_o=1 and held; clear_i -> ACTIVE, depth_o=0.
REQ-024 Marker bit: push plain 0x1000; ret_target_i=0x00001000 (MSB 0) -> mismatch_o=1, TRIPPED.
REQ-025 Overflow: DEPTH=8; 9 pushes of plain 0x100..0x108 -> overflow_o=1, depth_o=8; 8 returns of 0x108..0x101 all match; a 9th return gives underflow_o=1 and no crash.
REQ-026 Simultaneous events: push plain 0x200, then same-cycle call (plain 0x300) plus return 0x80000200 -> match, depth_o=1; the next return of 0x80000300 matches.
REQ-027 Reset and flush: assert rst_i during a pending compare -> no check_valid_o afterward, depth_o=0; flush_i with call_valid_i=1 -> depth_o=0.

Source files
------------

// File: rtl/ra_shadow_stack.sv
// Return-address shadow stack: keeps decoded return PCs for committed calls and
// checks each committed return target against the most recent one.
module ra_shadow_stack #(
  parameter int          DEPTH = 8,
  parameter int          VLEN  = 32,
  parameter logic [30:0] KEY   = 31'h73fa06c2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       flush_i,
  input  logic                       clear_i,
  input  logic                       call_valid_i,
  input  logic [VLEN-1:0]            call_link_i,
  input  logic                       ret_valid_i,
  input  logic [VLEN-1:0]            ret_target_i,
  output logic                       check_valid_o,
  output logic                       mismatch_o,
  output logic                       crash_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {DISABLED, ACTIVE, TRIPPED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   top_q, top_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            check_q, check_d;
  logic            mism_q, mism_d;
  logic            under_q, under_d;
  logic [30:0]     mem_q [DEPTH];

  logic            mem_we;
  logic [PW-1:0]   mem_waddr;
  logic [30:0]     mem_wdata;
  logic            ops, do_pop, do_push, empty, full, hit;
  logic [PW-1:0]   top_m1;
  logic [30:0]     popped;
  logic            unused_bits;

  assign unused_bits = ^{call_link_i, ret_target_i};

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == DW'(DEPTH));
    top_m1    = top_q - 1'b1;
    popped    = mem_q[top_m1];
    ops       = (state_q == ACTIVE) && en_i && !flush_i;
    do_pop    = ops && ret_valid_i && !empty;
    do_push   = ops && call_valid_i;
    hit       = ret_target_i[VLEN-1] && (ret_target_i[30:0] == popped);

    state_d   = state_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    check_d   = do_pop;
    mism_d    = do_pop && !hit;
    under_d   = ops && ret_valid_i && empty;
    mem_we    = 1'b0;
    mem_waddr = top_q;
    mem_wdata = call_link_i[30:0] ^ KEY;

    // A same-cycle call reuses the slot the return just freed, so depth is unchanged
    if (flush_i) begin
      top_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (do_pop && do_push) begin
      mem_we    = 1'b1;
      mem_waddr = top_m1;
    end else if (do_pop) begin
      top_d = top_m1;
      cnt_d = cnt_q - 1'b1;
    end else if (do_push) begin
      mem_we = 1'b1;
      top_d  = top_q + 1'b1;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + 1'b1;
    end

    // Flush never moves the state; leaving ACTIVE or TRIPPED via en/clear empties the stack
    case (state_q)
      DISABLED: if (en_i && !flush_i) state_d = ACTIVE;
      ACTIVE: begin
        if (!flush_i) begin
          if (!en_i) begin
            state_d = DISABLED;
            top_d   = '0;
            cnt_d   = '0;
          end else if (mism_d) begin
            if (clear_i) begin
              top_d = '0;
              cnt_d = '0;
            end else begin
              state_d = TRIPPED;
            end
          end
        end
      end
      TRIPPED: begin
        if (!flush_i && clear_i) begin
          state_d = ACTIVE;
          top_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = DISABLED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DISABLED;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      check_q <= 1'b0;
      mism_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      check_q <= check_d;
      mism_q  <= mism_d;
      under_q <= under_d;
    end
  end

  // Storage has no reset; entries at or above depth_o are never read as valid
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign check_valid_o = check_q;
  assign mismatch_o    = mism_q;
  assign crash_o       = (state_q == TRIPPED);
  assign overflow_o    = ovf_q;
  assign underflow_o   = under_q;
  assign depth_o       = cnt_q;

endmodule

// File: tb/tb_ra_shadow_stack.sv
// Bench for ra_shadow_stack: a queue-based model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ra_shadow_stack;

   localparam int          DEPTH = 8;
   localparam logic [30:0] KEY   = 31'h73fa06c2;
   localparam int M_DIS  = 0;
   localparam int M_ACT  = 1;
   localparam int M_TRIP = 2;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        en    = 1'b0;
   logic        flush = 1'b0;
   logic        clr   = 1'b0;
   logic        cv    = 1'b0;
   logic        rv    = 1'b0;
   logic [31:0] link  = '0;
   logic [31:0] tgt   = '0;

   logic        checkValid, mismatch, crash, overflow, underflow;
   logic [3:0]  depth;

   int nCompared   = 0;
   int nMismatched = 0;

   ra_shadow_stack #(.DEPTH(DEPTH), .VLEN(32), .KEY(KEY)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .flush_i(flush), .clear_i(clr),
      .call_valid_i(cv), .call_link_i(link), .ret_valid_i(rv), .ret_target_i(tgt),
      .check_valid_o(checkValid), .mismatch_o(mismatch), .crash_o(crash),
      .overflow_o(overflow), .underflow_o(underflow), .depth_o(depth)
   );

   always #5 clk = ~clk;

   // Reference model: the stack is a queue of plain return PCs, newest at the back
   int          mState;
   logic [30:0] mStack[$];
   logic [30:0] mTop;
   bit          mOvf, mCheck, mMism, mUnder;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mState = M_DIS;
         mStack.delete();
         mOvf = 0; mCheck = 0; mMism = 0; mUnder = 0;
      end else begin
         mCheck = 0; mMism = 0; mUnder = 0;
         if (flush) begin
            mStack.delete();
            mOvf = 0;
         end else if (mState == M_DIS) begin
            if (en) mState = M_ACT;
         end else if (mState == M_TRIP) begin
            if (clr) begin
               mState = M_ACT;
               mStack.delete();
            end
         end else if (!en) begin
            mState = M_DIS;
            mStack.delete();
         end else begin
            if (rv) begin
               if (mStack.size() == 0) mUnder = 1;
               else begin
                  mTop   = mStack.pop_back();
                  mCheck = 1;
                  mMism  = !(tgt[31] && tgt[30:0] == mTop);
               end
            end
            if (cv) begin
               if (mStack.size() == DEPTH) begin
                  void'(mStack.pop_front());
                  mOvf = 1;
               end
               mStack.push_back(link[30:0] ^ KEY);
            end
            if (mMism) begin
               if (clr) mStack.delete();
               else     mState = M_TRIP;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle, compare all outputs against the model on the falling edge
   always @(negedge clk) begin
      checkOutput("cyc_check_valid", 32'(checkValid), 32'(mCheck));
      checkOutput("cyc_mismatch",    32'(mismatch),   32'(mMism));
      checkOutput("cyc_underflow",   32'(underflow),  32'(mUnder));
      checkOutput("cyc_overflow",    32'(overflow),   32'(mOvf));
      checkOutput("cyc_crash",       32'(crash),      32'(mState == M_TRIP));
      checkOutput("cyc_depth",       32'(depth),      32'(mStack.size()));
   end

   // Drive one cycle of inputs, then land just after the edge that consumed them
   task automatic applyStimulus(input logic e, input logic f, input logic c,
                                input logic callV, input logic [31:0] callL,
                                input logic retV, input logic [31:0] retT);
      en = e; flush = f; clr = c; cv = callV; link = callL; rv = retV; tgt = retT;
      @(posedge clk);
      #1;
   endtask

   task automatic pushPlain(input logic [30:0] p);
      applyStimulus(1, 0, 0, 1, {1'b0, p ^ KEY}, 0, 32'h0);
   endtask

   task automatic retTarget(input logic [31:0] t);
      applyStimulus(1, 0, 0, 0, 32'h0, 1, t);
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_check_valid", 32'(checkValid), 32'h0);
      checkOutput("rst_crash",       32'(crash),      32'h0);
      checkOutput("rst_depth",       32'(depth),      32'h0);
      rst = 1'b0;
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      checkOutput("enable_crash", 32'(crash), 32'h0);

      // Matching return
      applyStimulus(1, 0, 0, 1, 32'h73fa16c2, 0, 32'h0);
      checkOutput("match_depth_after_push", 32'(depth), 32'h1);
      retTarget(32'h80001000);
      checkOutput("match_check_valid", 32'(checkValid), 32'h1);
      checkOutput("match_mismatch",    32'(mismatch),   32'h0);
      checkOutput("match_depth",       32'(depth),      32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      checkOutput("match_pulse_gone", 32'(checkValid), 32'h0);

      // Wrong target trips the checker; crash holds and pushes are ignored
      pushPlain(31'h1000);
      retTarget(32'h80001004);
      checkOutput("mism_mismatch", 32'(mismatch), 32'h1);
      checkOutput("mism_crash",    32'(crash),    32'h1);
      pushPlain(31'h1234);
      checkOutput("tripped_crash_held", 32'(crash), 32'h1);
      checkOutput("tripped_depth_held", 32'(depth), 32'h0);
      applyStimulus(1, 0, 1, 0, 32'h0, 0, 32'h0);
      checkOutput("clear_crash", 32'(crash), 32'h0);
      checkOutput("clear_depth", 32'(depth), 32'h0);

      // Missing marker bit
      pushPlain(31'h1000);
      retTarget(32'h00001000);
      checkOutput("marker_mismatch", 32'(mismatch), 32'h1);
      checkOutput("marker_crash",    32'(crash),    32'h1);
      applyStimulus(1, 0, 1, 0, 32'h0, 0, 32'h0);

      // Clear in the same cycle as a mismatch
      pushPlain(31'h1000);
      applyStimulus(1, 0, 1, 0, 32'h0, 1, 32'h80002000);
      checkOutput("clrmism_mismatch", 32'(mismatch), 32'h1);
      checkOutput("clrmism_crash",    32'(crash),    32'h0);

      // Overflow: nine pushes into eight slots, then drain
      for (int i = 0; i < 9; i++) pushPlain(31'(32'h100 + i));
      checkOutput("ovf_flag",        32'(overflow),       32'h1);
      checkOutput("ovf_depth",       32'(depth),          32'h8);
      checkOutput("ovf_model_depth", 32'(mStack.size()),  32'h8);
      for (int i = 8; i >= 1; i--) begin
         retTarget(32'h80000100 + 32'(i));
         checkOutput("drain_check_valid", 32'(checkValid), 32'h1);
         checkOutput("drain_mismatch",    32'(mismatch),   32'h0);
      end
      retTarget(32'h80000100);
      checkOutput("empty_underflow",   32'(underflow),  32'h1);
      checkOutput("empty_check_valid", 32'(checkValid), 32'h0);
      checkOutput("empty_crash",       32'(crash),      32'h0);
      checkOutput("empty_ovf_sticky",  32'(overflow),   32'h1);
      applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
      checkOutput("flush_clears_ovf", 32'(overflow), 32'h0);

      // Call and return in the same cycle
      pushPlain(31'h200);
      applyStimulus(1, 0, 0, 1, {1'b0, 31'h300 ^ KEY}, 1, 32'h80000200);
      checkOutput("simul_check_valid", 32'(checkValid), 32'h1);
      checkOutput("simul_mismatch",    32'(mismatch),   32'h0);
      checkOutput("simul_depth",       32'(depth),      32'h1);
      retTarget(32'h80000300);
      checkOutput("simul_next_mismatch", 32'(mismatch), 32'h0);
      checkOutput("simul_next_depth",    32'(depth),    32'h0);

      // Wrap the pointer past the end with simultaneous traffic while full
      for (int i = 0; i < 10; i++) pushPlain(31'(32'h40 + i));
      applyStimulus(1, 0, 0, 1, {1'b0, 31'h77 ^ KEY}, 1, 32'h80000049);
      for (int i = 0; i < 3; i++) retTarget(32'h80000000 | 32'(i == 0 ? 32'h77 : 32'h48 - i + 1));
      applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);

      // Reset while a compare is pending
      pushPlain(31'h400);
      en = 1; flush = 0; clr = 0; cv = 0; rv = 1; tgt = 32'h80000400; rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      checkOutput("rstmid_check_valid", 32'(checkValid), 32'h0);
      checkOutput("rstmid_depth",       32'(depth),      32'h0);
      applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
      checkOutput("rstmid_after_check", 32'(checkValid), 32'h0);

      // Flush beats a same-cycle call
      pushPlain(31'h500);
      applyStimulus(1, 1, 0, 1, {1'b0, 31'h600 ^ KEY}, 0, 32'h0);
      checkOutput("flush_call_depth", 32'(depth), 32'h0);

      // Disabling empties the stack and suppresses all pulses
      pushPlain(31'h700);
      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      checkOutput("disable_depth", 32'(depth), 32'h0);
      applyStimulus(0, 0, 0, 1, 32'h0, 1, 32'h80000700);
      checkOutput("disabled_underflow", 32'(underflow), 32'h0);
      checkOutput("disabled_depth",     32'(depth),     32'h0);

      applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
